s2c_axis_egress: RTL and testbench
==================================

# s2c_axis_egress

System-to-card stream egress for one S2C scatter-gather channel. Accepts read-completion beats that the PCIe completion router has already tagged to this channel, buffers them, and presents them to the application as an AXI-Stream master with packet framing taken from the per-burst context word. It is the counterpart of the C2S channel's AXI-Stream slave ingress, and sits between the completion router and the user logic.

## Interface
Parameters:
- CHAN_NUM, 0: channel index; no functional effect.
- PCIE_CORE_DATA_WIDTH, 128: beat width W in bits; must be 64, 128 or 256.
- SWAP_ENDIAN, 1: when 1, reverse the byte order inside each 32-bit dword of data.
- BUFFES_SIZE_LOG_OF2, 6: beat FIFO depth is 2^N entries.

Ports:
- clk_i  in  1  sole clock.
- reset_i  in  1  reset; synchronous, active-high.
- chan_ena_i  in  1  channel enable; level.
- bm_data_i  in  W  completion beat data.
- bm_be_i  in  W/8  byte enables for the beat.
- bm_rx_active_i  in  1  beat valid.
- bm_rx_rdy_o  out  1  ready for a beat.
- bm_rx_last_in_burst_i  in  1  this beat is the last beat of the burst.
- bm_rx_done_i  in  1  single-cycle pulse: burst completed.
- bm_context_i  in  32  burst context. Bit 31 is EOP: the burst ends a packet.
- m_axis_tdata  out  W  stream data.
- m_axis_tkeep  out  W/32  dword keep.
- m_axis_tlast  out  1  end of packet.
- m_axis_tvalid  out  1  valid.
- m_axis_tuser  out  33  [31:0] is the burst context; [32] is SOP.
- m_axis_tready  in  1  ready.
- fifo_level_o  out  N+1  FIFO occupancy in beats.
- overflow_o  out  1  sticky flag: a beat was dropped. Cleared only by reset.
- burst_count_o  out  32  count of bm_rx_done_i pulses accepted while in RUN.
- pkt_count_o  out  32  count of packets delivered (tlast handshakes).

## Operation
- A beat is accepted when bm_rx_active_i && bm_rx_rdy_o. It is then written to the FIFO as {data, keep, last, context, sop}.
- Beat formatting:
  - keep[i] = |bm_be_i[4i+3:4i].
  - last = bm_rx_last_in_burst_i && bm_context_i[31].
  - sop = 1 on the first beat written after reset, after a beat with last=1, or after leaving IDLE.
  - Data is dword byte-swapped when SWAP_ENDIAN=1.
- Overflow: if bm_rx_active_i is high while the FIFO is full, the beat is dropped and overflow_o is set. The router must honour bm_rx_rdy_o, so overflow is an error indicator only.
- FSM with states IDLE, RUN, DRAIN:
  - IDLE: bm_rx_rdy_o=0, FIFO held empty. Moves to RUN when chan_ena_i=1.
  - RUN: normal operation. Moves to DRAIN when chan_ena_i=0.
  - DRAIN: bm_rx_rdy_o=0; incoming beats are ignored and do not set overflow. The output keeps delivering until a tlast beat is handshaken or the FIFO and output register are empty. Any remaining content is then flushed in one cycle, and the FSM returns to IDLE. A chan_ena_i=1 seen during DRAIN is ignored until IDLE is reached.
- Counters wrap modulo 2^32.

## Timing
- Reset values: bm_rx_rdy_o=0, m_axis_tvalid=0, m_axis_tlast=0, tdata/tkeep/tuser=0, fifo_level_o=0, overflow_o=0, both counters=0. FSM resets to IDLE.
- bm_rx_rdy_o is registered. It is 1 in RUN when fifo_level_o <= 2^N-3, which gives a margin for the one-cycle ready lag.
- Latency: a beat accepted in cycle t is visible on m_axis_tvalid in cycle t+2, provided the output register is empty.
- Throughput: 1 beat/cycle sustained with tready held at 1.
- AXI-S output rules:
  - Once tvalid is high, tdata/tkeep/tlast/tuser stay stable until the tready handshake.
  - The output register reloads from the FIFO in the handshake cycle, so there is no bubble.
- A FIFO write and read in the same cycle leaves fifo_level_o unchanged.
- Reset mid-packet drops all content. The next beat accepted after reset carries sop=1.

## Structure
- Package s2c_pkg holds:
  - CTX_EOP_BIT=31.
  - TUSER_SOP_BIT=32.
  - Enum s2c_egress_state_t {IDLE, RUN, DRAIN}.
  - Function dword_swap(W).
- Sub-module s2c_beat_fifo: a synchronous FIFO of width W + W/32 + 1 + 32 + 1 and depth 2^N. It provides level, full and empty outputs and a single-cycle flush input.

## Test plan
- RUN, W=128, one 4-beat burst, context=0x8000_0005, all BE=1, tready=1:
  - four beats appear starting 2 cycles after the first accept;
  - tuser[32]=1 on beat 0 only; tlast on beat 3;
  - tuser[31:0]=0x8000_0005;
  - pkt_count_o=1.
- Data 0x00112233_44556677_8899AABB_CCDDEEFF with SWAP_ENDIAN=1 -> tdata=0x33221100_77665544_BBAA9988_FFEEDDCC. bm_be_i=0x0FFF -> tkeep=0x7.
- tready=0, 64 beats offered -> bm_rx_rdy_o drops at level 62, no overflow. Forcing bm_rx_active_i while full -> overflow_o=1 and the beat is absent from the output.
- Two bursts, the first with EOP=0 and the second with EOP=1 -> a single packet, one sop, one tlast, burst_count_o=2.
- chan_ena_i cleared mid-packet with 3 beats buffered and the tlast beat second -> two beats delivered, the third flushed, FSM in IDLE, fifo_level_o=0.
- reset_i pulsed mid-stream -> all outputs return to reset values next cycle; the next beat after re-enable carries sop=1.

Source files
------------

// File: rtl/s2c_pkg.sv
// Shared constants, FSM state type and the dword byte-swap helper for the S2C egress path.
package s2c_pkg;
    localparam int CTX_EOP_BIT   = 31;
    localparam int TUSER_SOP_BIT = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } s2c_egress_state_t;

    // Applied per 32-bit dword; the top slices the beat and calls this once per dword.
    function automatic logic [31:0] dword_swap(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction
endpackage

// File: rtl/s2c_beat_fifo.sv
// Beat FIFO for the S2C egress path: show-ahead read data, occupancy count, single-cycle flush.
module s2c_beat_fifo #(
    parameter int WIDTH = 8,
    parameter int AW    = 6
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             flush_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic [AW:0]      level_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int          DEPTH    = 1 << AW;
    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             w_wr;
    logic             w_rd;

    assign full_o    = (r_level == LVL_FULL);
    assign empty_o   = (r_level == '0);
    assign w_wr      = wr_en_i && !full_o;
    assign w_rd      = rd_en_i && !empty_o;
    assign level_o   = r_level;
    assign rd_data_o = r_mem[r_rd_ptr];

    always_ff @(posedge clk_i) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i || flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_wr && !w_rd)      r_level <= r_level + (AW+1)'(1);
            else if (!w_wr && w_rd) r_level <= r_level - (AW+1)'(1);
        end
    end
endmodule

// File: rtl/s2c_axis_egress.sv
// S2C channel egress: buffers router-tagged completion beats and replays them as an AXI-Stream master.
//   state | meaning
//   IDLE  | channel off, FIFO and output register held empty, not ready
//   RUN   | accepting beats and streaming them out
//   DRAIN | not ready; finish current packet (or run dry), then flush and go IDLE
module s2c_axis_egress
    import s2c_pkg::*;
#(
    parameter int CHAN_NUM             = 0,
    parameter int PCIE_CORE_DATA_WIDTH = 128,
    parameter int SWAP_ENDIAN          = 1,
    parameter int BUFFES_SIZE_LOG_OF2  = 6
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic                              chan_ena_i,
    input  logic [PCIE_CORE_DATA_WIDTH-1:0]   bm_data_i,
    input  logic [PCIE_CORE_DATA_WIDTH/8-1:0] bm_be_i,
    input  logic                              bm_rx_active_i,
    output logic                              bm_rx_rdy_o,
    input  logic                              bm_rx_last_in_burst_i,
    input  logic                              bm_rx_done_i,
    input  logic [31:0]                       bm_context_i,
    output logic [PCIE_CORE_DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [PCIE_CORE_DATA_WIDTH/32-1:0] m_axis_tkeep,
    output logic                              m_axis_tlast,
    output logic                              m_axis_tvalid,
    output logic [32:0]                       m_axis_tuser,
    input  logic                              m_axis_tready,
    output logic [BUFFES_SIZE_LOG_OF2:0]      fifo_level_o,
    output logic                              overflow_o,
    output logic [31:0]                       burst_count_o,
    output logic [31:0]                       pkt_count_o
);
    localparam int         W       = PCIE_CORE_DATA_WIDTH;
    localparam int         KW      = W / 32;
    localparam int         N       = BUFFES_SIZE_LOG_OF2;
    localparam int         DEPTH   = 1 << N;
    localparam int         FW      = W + KW + 1 + 32 + 1;
    localparam logic [N:0] LVL_ONE = (N+1)'(1);
    localparam logic [N:0] RDY_MAX = (N+1)'(DEPTH - 3);

    if (!(W == 64 || W == 128 || W == 256) || CHAN_NUM < 0 || N < 2) begin : g_bad_param
        $error("s2c_axis_egress: unsupported parameter set");
    end

    s2c_egress_state_t r_state, w_state_nxt;
    logic          w_fifo_full, w_fifo_empty, w_fifo_wr, w_fifo_rd, w_flush;
    logic          w_hs, w_drain_done, w_load, w_last_fmt;
    logic [N:0]    w_level, w_level_nxt;
    logic [W-1:0]  w_data_fmt;
    logic [KW-1:0] w_keep_fmt;
    logic [FW-1:0] w_wr_entry, w_rd_entry;
    logic          r_sop_pend, r_rdy, r_ovf;
    logic [31:0]   r_burst_cnt, r_pkt_cnt;
    logic          r_tvalid, r_tlast;
    logic [W-1:0]  r_tdata;
    logic [KW-1:0] r_tkeep;
    logic [32:0]   r_tuser;

    for (genvar g = 0; g < KW; g++) begin : g_dw
        assign w_data_fmt[32*g +: 32] = (SWAP_ENDIAN != 0) ? dword_swap(bm_data_i[32*g +: 32])
                                                            : bm_data_i[32*g +: 32];
        assign w_keep_fmt[g] = |bm_be_i[4*g +: 4];
    end

    assign w_last_fmt = bm_rx_last_in_burst_i && bm_context_i[CTX_EOP_BIT];
    // Entry layout, LSB first: sop, context[31:0], last, keep, data.
    assign w_wr_entry = {w_data_fmt, w_keep_fmt, w_last_fmt, bm_context_i, r_sop_pend};

    assign w_hs         = r_tvalid && m_axis_tready;
    assign w_drain_done = (r_state == DRAIN) && ((w_hs && r_tlast) || (w_fifo_empty && !r_tvalid));
    assign w_flush      = (r_state == IDLE) || w_drain_done;
    assign w_fifo_wr    = (r_state == RUN) && bm_rx_active_i && !w_fifo_full;
    assign w_load       = (r_state != IDLE) && !w_fifo_empty && (!r_tvalid || m_axis_tready)
                          && !w_drain_done;
    assign w_fifo_rd    = w_load;

    s2c_beat_fifo #(.WIDTH(FW), .AW(N)) u_fifo (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .flush_i   (w_flush),
        .wr_en_i   (w_fifo_wr),
        .wr_data_i (w_wr_entry),
        .rd_en_i   (w_fifo_rd),
        .rd_data_o (w_rd_entry),
        .level_o   (w_level),
        .full_o    (w_fifo_full),
        .empty_o   (w_fifo_empty)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (chan_ena_i)   w_state_nxt = RUN;
            RUN:     if (!chan_ena_i)  w_state_nxt = DRAIN;
            DRAIN:   if (w_drain_done) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Ready is registered from next-cycle occupancy, so it reflects the level it is shown with.
    always_comb begin
        w_level_nxt = w_level;
        if (w_flush)                     w_level_nxt = '0;
        else if (w_fifo_wr && !w_fifo_rd) w_level_nxt = w_level + LVL_ONE;
        else if (!w_fifo_wr && w_fifo_rd) w_level_nxt = w_level - LVL_ONE;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_rdy       <= 1'b0;
            r_ovf       <= 1'b0;
            r_sop_pend  <= 1'b1;
            r_burst_cnt <= '0;
            r_pkt_cnt   <= '0;
        end else begin
            r_rdy <= (w_state_nxt == RUN) && (w_level_nxt <= RDY_MAX);
            if ((r_state == RUN) && bm_rx_active_i && w_fifo_full) r_ovf <= 1'b1;
            if (r_state == IDLE) r_sop_pend <= 1'b1;
            else if (w_fifo_wr)  r_sop_pend <= w_last_fmt;
            if ((r_state == RUN) && bm_rx_done_i) r_burst_cnt <= r_burst_cnt + 32'd1;
            if (w_hs && r_tlast)                  r_pkt_cnt   <= r_pkt_cnt + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i || w_flush) begin
            r_tvalid <= 1'b0;
            r_tdata  <= '0;
            r_tkeep  <= '0;
            r_tlast  <= 1'b0;
            r_tuser  <= '0;
        end else if (w_load) begin
            r_tvalid                <= 1'b1;
            r_tdata                 <= w_rd_entry[FW-1 -: W];
            r_tkeep                 <= w_rd_entry[34 +: KW];
            r_tlast                 <= w_rd_entry[33];
            r_tuser[31:0]           <= w_rd_entry[32:1];
            r_tuser[TUSER_SOP_BIT]  <= w_rd_entry[0];
        end else if (w_hs) begin
            r_tvalid <= 1'b0;
        end
    end

    assign bm_rx_rdy_o   = r_rdy;
    assign m_axis_tdata  = r_tdata;
    assign m_axis_tkeep  = r_tkeep;
    assign m_axis_tlast  = r_tlast;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tuser  = r_tuser;
    assign fifo_level_o  = w_level;
    assign overflow_o    = r_ovf;
    assign burst_count_o = r_burst_cnt;
    assign pkt_count_o   = r_pkt_cnt;
endmodule

// File: tb/tb_s2c_axis_egress.sv
// Bench for s2c_axis_egress: directed scenarios plus random traffic against a queue-based reference model.
module tb_s2c_axis_egress;
    localparam int W = 128, KW = 4, N = 6, DEPTH = 64;

    logic           clk_i = 1'b0;
    logic           reset_i, chan_ena_i;
    logic [W-1:0]   bm_data_i;
    logic [W/8-1:0] bm_be_i;
    logic           bm_rx_active_i, bm_rx_rdy_o, bm_rx_last_in_burst_i, bm_rx_done_i;
    logic [31:0]    bm_context_i;
    logic [W-1:0]   m_axis_tdata;
    logic [KW-1:0]  m_axis_tkeep;
    logic           m_axis_tlast, m_axis_tvalid, m_axis_tready;
    logic [32:0]    m_axis_tuser;
    logic [N:0]     fifo_level_o;
    logic           overflow_o;
    logic [31:0]    burst_count_o, pkt_count_o;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    s2c_axis_egress #(.CHAN_NUM(0), .PCIE_CORE_DATA_WIDTH(W), .SWAP_ENDIAN(1),
                      .BUFFES_SIZE_LOG_OF2(N)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .chan_ena_i(chan_ena_i),
        .bm_data_i(bm_data_i), .bm_be_i(bm_be_i), .bm_rx_active_i(bm_rx_active_i),
        .bm_rx_rdy_o(bm_rx_rdy_o), .bm_rx_last_in_burst_i(bm_rx_last_in_burst_i),
        .bm_rx_done_i(bm_rx_done_i), .bm_context_i(bm_context_i),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tuser(m_axis_tuser), .m_axis_tready(m_axis_tready),
        .fifo_level_o(fifo_level_o), .overflow_o(overflow_o),
        .burst_count_o(burst_count_o), .pkt_count_o(pkt_count_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: what sits in the buffer, what sits on the bus, and the channel mode.
    typedef struct packed {
        logic [W-1:0]  d;
        logic [KW-1:0] k;
        logic          l;
        logic [31:0]   c;
        logic          s;
    } ent_t;

    function automatic ent_t mk(input logic [W-1:0] d, input logic [W/8-1:0] be,
                                input logic lb, input logic [31:0] c);
        ent_t e;
        e = '0;
        for (int b = 0; b < W/8; b++) e.d[8*(4*(b/4) + 3 - (b%4)) +: 8] = d[8*b +: 8];
        for (int i = 0; i < KW; i++) e.k[i] = (be[4*i +: 4] != 4'h0);
        e.l = lb && c[31];
        e.c = c;
        return e;
    endfunction

    ent_t        fq[$];
    ent_t        mo = '0;
    bit          mv = 0, m_sop = 1, m_rdy = 0, m_ovf = 0;
    int          mode = 0;   // 0 off, 1 running, 2 finishing
    int unsigned m_burst = 0, m_pkt = 0;

    always @(posedge clk_i) begin : model
        bit   hs, fin, ld, wr;
        int   nmode;
        ent_t e;
        if (reset_i) begin
            fq.delete(); mv = 0; mo = '0; mode = 0; m_sop = 1;
            m_rdy = 0; m_ovf = 0; m_burst = 0; m_pkt = 0;
        end else begin
            hs  = mv && m_axis_tready;
            fin = (mode == 2) && ((hs && mo.l) || (fq.size() == 0 && !mv));
            ld  = (mode != 0) && (fq.size() > 0) && (!mv || m_axis_tready) && !fin;
            wr  = (mode == 1) && bm_rx_active_i && (fq.size() < DEPTH);
            if ((mode == 1) && bm_rx_active_i && fq.size() == DEPTH) m_ovf = 1;
            if ((mode == 1) && bm_rx_done_i) m_burst++;
            if (hs && mo.l) m_pkt++;
            e = mk(bm_data_i, bm_be_i, bm_rx_last_in_burst_i, bm_context_i);
            e.s = m_sop;
            if (mode == 0 || fin) begin
                mv = 0; mo = '0; fq.delete();
            end else begin
                if (ld) begin mo = fq.pop_front(); mv = 1; end
                else if (hs) mv = 0;
                if (wr) fq.push_back(e);
            end
            if (mode == 0) m_sop = 1;
            else if (wr)   m_sop = e.l;
            nmode = mode;
            if (mode == 0 && chan_ena_i)  nmode = 1;
            if (mode == 1 && !chan_ena_i) nmode = 2;
            if (fin)                      nmode = 0;
            m_rdy = (nmode == 1) && (fq.size() <= DEPTH - 3);
            mode  = nmode;
        end
    end

    always @(negedge clk_i) begin
        if (chk_en) begin
            chk("rdy", bm_rx_rdy_o, m_rdy);
            chk("tvalid", m_axis_tvalid, mv);
            chk("level", fifo_level_o, fq.size());
            chk("overflow", overflow_o, m_ovf);
            chk("burst_count", burst_count_o, m_burst);
            chk("pkt_count", pkt_count_o, m_pkt);
            if (mv) begin
                chk("tdata", m_axis_tdata, mo.d);
                chk("tkeep", m_axis_tkeep, mo.k);
                chk("tlast", m_axis_tlast, mo.l);
                chk("tuser", m_axis_tuser, {mo.s, mo.c});
            end
        end
    end

    task automatic drive(input logic act, input logic [W-1:0] d, input logic [15:0] be,
                         input logic lb, input logic [31:0] c, input logic dn);
        bm_rx_active_i = act; bm_data_i = d; bm_be_i = be;
        bm_rx_last_in_burst_i = lb; bm_context_i = c; bm_rx_done_i = dn;
        @(negedge clk_i);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic wait_valid(input string nm);
        int n = 0;
        while (!m_axis_tvalid && n < 20) begin @(negedge clk_i); n++; end
        chk({nm, "_valid_timeout"}, m_axis_tvalid, 1'b1);
    endtask

    task automatic wait_empty(input string nm);
        int n = 0;
        while ((m_axis_tvalid || fifo_level_o != '0) && n < 300) begin @(negedge clk_i); n++; end
        chk({nm, "_empty_timeout"}, {m_axis_tvalid, fifo_level_o}, '0);
    endtask

    localparam logic [W-1:0] D_SPEC = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [W-1:0] D_SWAP = 128'h33221100_77665544_BBAA9988_FFEEDDCC;

    initial begin
        reset_i = 1; chan_ena_i = 0; m_axis_tready = 1;
        bm_rx_active_i = 0; bm_data_i = '0; bm_be_i = '0;
        bm_rx_last_in_burst_i = 0; bm_context_i = '0; bm_rx_done_i = 0;
        repeat (3) @(negedge clk_i);
        chk("rst_tvalid", m_axis_tvalid, 1'b0);
        chk("rst_rdy", bm_rx_rdy_o, 1'b0);
        chk("rst_outs", {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser}, '0);
        chk("rst_level_ovf", {fifo_level_o, overflow_o}, '0);
        chk("rst_counts", {burst_count_o, pkt_count_o}, '0);
        reset_i = 0; chk_en = 1;

        // One 4-beat packet burst, latency and framing
        chan_ena_i = 1;
        @(negedge clk_i);
        chk("run_rdy", bm_rx_rdy_o, 1'b1);
        drive(1'b1, D_SPEC, 16'hFFFF, 1'b0, 32'h8000_0005, 1'b0);
        chk("lat_t1_tvalid", m_axis_tvalid, 1'b0);
        drive(1'b1, 128'h1, 16'hFFFF, 1'b0, 32'h8000_0005, 1'b0);
        chk("lat_t2_tvalid", m_axis_tvalid, 1'b1);
        chk("b0_tdata_swap", m_axis_tdata, D_SWAP);
        chk("b0_tuser_sop", m_axis_tuser, 33'h1_8000_0005);
        drive(1'b1, 128'h2, 16'hFFFF, 1'b0, 32'h8000_0005, 1'b0);
        chk("b1_no_sop", m_axis_tuser[32], 1'b0);
        drive(1'b1, 128'h3, 16'hFFFF, 1'b1, 32'h8000_0005, 1'b1);
        chk("b2_no_tlast", m_axis_tlast, 1'b0);
        idle(1);
        chk("b3_tlast", {m_axis_tvalid, m_axis_tlast}, 2'b11);
        idle(4);
        chk("pkt_after_burst", pkt_count_o, 32'd1);
        chk("burst_after_burst", burst_count_o, 32'd1);

        // Partial byte enables map to dword keep
        drive(1'b1, D_SPEC, 16'h0FFF, 1'b1, 32'h8000_0000, 1'b1);
        idle(1);
        wait_valid("keep");
        chk("keep_0fff", m_axis_tkeep, 4'h7);
        idle(4);

        // Two bursts forming one packet
        drive(1'b1, 128'hA0, 16'hFFFF, 1'b0, 32'h0000_0011, 1'b0);
        drive(1'b1, 128'hA1, 16'hFFFF, 1'b1, 32'h0000_0011, 1'b1);
        drive(1'b1, 128'hA2, 16'hFFFF, 1'b0, 32'h8000_0012, 1'b0);
        drive(1'b1, 128'hA3, 16'hFFFF, 1'b1, 32'h8000_0012, 1'b1);
        idle(6);
        chk("two_burst_pkt", pkt_count_o, 32'd3);
        chk("two_burst_burst", burst_count_o, 32'd4);

        // Backpressure: ready falls at level 62, then forced beats overflow
        m_axis_tready = 0;
        for (int i = 0; i < 80 && bm_rx_rdy_o; i++)
            drive(1'b1, W'(32'h1000 + i), 16'hFFFF, 1'b0, 32'h0000_0020, 1'b0);
        chk("rdy_drop_level", fifo_level_o, 62);
        chk("rdy_drop_no_ovf", overflow_o, 1'b0);
        for (int i = 0; i < 4; i++)
            drive(1'b1, W'(32'h2000 + i), 16'hFFFF, 1'b0, 32'h0000_0020, 1'b0);
        idle(1);
        chk("full_level", fifo_level_o, 64);
        chk("ovf_set", overflow_o, 1'b1);
        m_axis_tready = 1;
        wait_empty("bp_drain");
        idle(2);

        // Disable mid-packet: tlast beat second, third beat flushed
        m_axis_tready = 0;
        drive(1'b1, 128'hB0, 16'hFFFF, 1'b0, 32'h8000_0030, 1'b0);
        drive(1'b1, 128'hB1, 16'hFFFF, 1'b1, 32'h8000_0030, 1'b0);
        drive(1'b1, 128'hB2, 16'hFFFF, 1'b0, 32'h8000_0031, 1'b0);
        chan_ena_i = 0;
        idle(2);
        m_axis_tready = 1;
        wait_empty("drain");
        idle(2);
        chk("drain_pkt", pkt_count_o, 32'd4);
        chk("drain_idle_level", fifo_level_o, 0);
        chk("drain_idle_rdy", bm_rx_rdy_o, 1'b0);

        // Reset mid-stream
        chan_ena_i = 1;
        idle(1);
        m_axis_tready = 0;
        drive(1'b1, 128'hC0, 16'hFFFF, 1'b0, 32'h0000_0040, 1'b1);
        drive(1'b1, 128'hC1, 16'hFFFF, 1'b0, 32'h0000_0040, 1'b0);
        drive(1'b1, 128'hC2, 16'hFFFF, 1'b0, 32'h0000_0040, 1'b0);
        reset_i = 1;
        idle(1);
        chk("rst2_tvalid_rdy", {m_axis_tvalid, bm_rx_rdy_o}, 2'b00);
        chk("rst2_outs", {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser}, '0);
        chk("rst2_level_ovf", {fifo_level_o, overflow_o}, '0);
        chk("rst2_counts", {burst_count_o, pkt_count_o}, '0);
        reset_i = 0;
        m_axis_tready = 1;
        idle(1);
        drive(1'b1, 128'hD0, 16'hFFFF, 1'b1, 32'h8000_0050, 1'b0);
        idle(1);
        wait_valid("post_rst");
        chk("post_rst_sop", m_axis_tuser[32], 1'b1);
        idle(3);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            int rp;
            rp = ((c / 400) % 2 == 1) ? 3 : 8;
            if ($urandom_range(0, 199) == 0) chan_ena_i = ~chan_ena_i;
            else if (!chan_ena_i && $urandom_range(0, 9) == 0) chan_ena_i = 1;
            m_axis_tready = ($urandom_range(0, 9) < rp);
            bm_rx_active_i = bm_rx_rdy_o ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 29) == 0);
            bm_data_i = {$urandom, $urandom, $urandom, $urandom};
            bm_be_i = 16'($urandom);
            bm_rx_last_in_burst_i = ($urandom_range(0, 3) == 0);
            bm_context_i = $urandom;
            bm_rx_done_i = ($urandom_range(0, 7) == 0);
            @(negedge clk_i);
        end
        m_axis_tready = 1;
        idle(120);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
